// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider between two requesters.
// Divide-by-zero is answered directly without starting the divider.
module div_arbiter #(
   parameter int WIDTH       = 32,
   parameter int DIV_LATENCY = 33
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             resp_valid,
   output logic             resp_id,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_q,
   output logic [WIDTH-1:0] resp_r,
   output logic             resp_dz,
   output logic             busy,
   output logic             div_start,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r
);

   localparam int CW = $clog2(DIV_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      BUSY,
      DONE
   } state_t;

   state_t          state;
   logic            ptr;
   logic [CW-1:0]   cnt;
   logic            grant0;
   logic            grant1;
   logic            acc0;
   logic            acc1;
   logic [WIDTH-1:0] selA;
   logic [WIDTH-1:0] selB;

   // On a tie the pointer port wins; a lone requester always wins.
   assign grant0 = req0_valid & (~req1_valid | ~ptr);
   assign grant1 = req1_valid & (~req0_valid | ptr);

   assign req0_ready = ~reset & (state == IDLE) & grant0;
   assign req1_ready = ~reset & (state == IDLE) & grant1;

   assign acc0 = req0_valid & req0_ready;
   assign acc1 = req1_valid & req1_ready;

   assign selA = acc1 ? req1_a : req0_a;
   assign selB = acc1 ? req1_b : req0_b;

   assign busy = (state != IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         cnt        <= '0;
         div_start  <= 1'b0;
         div_a      <= '0;
         div_b      <= '0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_q     <= '0;
         resp_r     <= '0;
         resp_dz    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (acc0 | acc1) begin
                  div_a   <= selA;
                  div_b   <= selB;
                  resp_id <= acc1;
                  if (selB == '0) begin
                     resp_q     <= '1;
                     resp_r     <= selA;
                     resp_dz    <= 1'b1;
                     resp_valid <= 1'b1;
                     state      <= DONE;
                  end else begin
                     div_start <= 1'b1;
                     state     <= START;
                  end
               end
            end
            START: begin
               div_start <= 1'b0;
               cnt       <= CW'(DIV_LATENCY - 1);
               state     <= BUSY;
            end
            BUSY: begin
               if (cnt == '0) begin
                  resp_q     <= div_q;
                  resp_r     <= div_r;
                  resp_dz    <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  ptr        <= ~resp_id;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a fixed-latency divider model.
// The model only shows the true quotient after exactly DIV_LATENCY edges.
module tb_div_arbiter;

   localparam int W   = 32;
   localparam int LAT = 33;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         req0_valid = 1'b0;
   logic         req0_ready;
   logic [W-1:0] req0_a = '0;
   logic [W-1:0] req0_b = '0;
   logic         req1_valid = 1'b0;
   logic         req1_ready;
   logic [W-1:0] req1_a = '0;
   logic [W-1:0] req1_b = '0;
   logic         resp_valid;
   logic         resp_id;
   logic         resp_ready = 1'b0;
   logic [W-1:0] resp_q;
   logic [W-1:0] resp_r;
   logic         resp_dz;
   logic         busy;
   logic         div_start;
   logic [W-1:0] div_a;
   logic [W-1:0] div_b;
   logic [W-1:0] div_q;
   logic [W-1:0] div_r;

   int nCmp = 0;
   int nErr = 0;

   always #5 clock = ~clock;

   div_arbiter #(.WIDTH(W), .DIV_LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(resp_valid), .resp_id(resp_id),
      .resp_ready(resp_ready), .resp_q(resp_q),
      .resp_r(resp_r), .resp_dz(resp_dz), .busy(busy),
      .div_start(div_start), .div_a(div_a), .div_b(div_b),
      .div_q(div_q), .div_r(div_r)
   );

   // Divider model: garbage until LAT edges after the start cycle.
   int edges = 0;
   always @(posedge clock) begin
      if (div_start) edges <= 1;
      else if (edges > 0 && edges < LAT) edges <= edges + 1;
   end
   assign div_q = (edges == LAT && div_b != 0) ? div_a / div_b : 32'hDEADBEEF;
   assign div_r = (edges == LAT && div_b != 0) ? div_a % div_b : 32'hBADC0DE5;

   // Called mid-cycle T+1 after an accept in T; cyc counts from T.
   task automatic wait_resp(output int cyc, output int nStart, output int sCyc);
      cyc = 0; nStart = 0; sCyc = 0;
      do begin
         @(negedge clock);
         cyc++;
         if (div_start) begin nStart++; sCyc = cyc; end
      end while (!resp_valid && cyc < 200);
   endtask

   task automatic release_resp();
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      nCmp++;
      if ({req0_ready, req1_ready, resp_valid, resp_id, resp_q, resp_r,
           resp_dz, busy, div_start, div_a, div_b} !== '0) begin
         nErr++;
         $display("FAIL reset_outputs: q=%h r=%h a=%h b=%h busy=%b rv=%b",
                  resp_q, resp_r, div_a, div_b, busy, resp_valid);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int cyc, ns, sc;
      @(negedge clock);
      req0_valid = 1'b1; req0_a = 100; req0_b = 7;
      #1;
      nCmp++;
      if (req0_ready !== 1'b1) begin
         nErr++; $display("FAIL basic_ready0: got %b want 1", req0_ready);
      end
      @(posedge clock); #1;
      req0_valid = 1'b0;
      wait_resp(cyc, ns, sc);
      nCmp++;
      if (cyc !== 35) begin
         nErr++; $display("FAIL basic_latency: got %0d want 35", cyc);
      end
      nCmp++;
      if (ns !== 1 || sc !== 1) begin
         nErr++; $display("FAIL basic_start: got n=%0d at %0d want n=1 at 1", ns, sc);
      end
      nCmp++;
      if ({resp_id, resp_q, resp_r, resp_dz} !== {1'b0, 32'd14, 32'd2, 1'b0}) begin
         nErr++;
         $display("FAIL basic_result: got id=%b q=%0d r=%0d dz=%b want 0/14/2/0",
                  resp_id, resp_q, resp_r, resp_dz);
      end
      nCmp++;
      if (div_a !== 100 || div_b !== 7) begin
         nErr++; $display("FAIL basic_operands: got %0d/%0d want 100/7", div_a, div_b);
      end
      release_resp();
      nCmp++;
      if (busy !== 1'b0 || resp_valid !== 1'b0) begin
         nErr++; $display("FAIL basic_idle: got busy=%b rv=%b want 0/0", busy, resp_valid);
      end
   endtask

   task automatic test_tie();
      int cyc, ns, sc;
      do_reset();
      req0_valid = 1'b1; req0_a = 50; req0_b = 5;
      req1_valid = 1'b1; req1_a = 9;  req1_b = 2;
      #1;
      nCmp++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         nErr++;
         $display("FAIL tie_grant: got r0=%b r1=%b want 1/0", req0_ready, req1_ready);
      end
      @(posedge clock); #1;
      req0_valid = 1'b0;
      wait_resp(cyc, ns, sc);
      nCmp++;
      if ({resp_id, resp_q, resp_r} !== {1'b0, 32'd10, 32'd0} || cyc !== 35) begin
         nErr++;
         $display("FAIL tie_first: got id=%b q=%0d r=%0d cyc=%0d want 0/10/0/35",
                  resp_id, resp_q, resp_r, cyc);
      end
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      nCmp++;
      if (req1_ready !== 1'b1) begin
         nErr++; $display("FAIL tie_second_grant: got %b want 1", req1_ready);
      end
      @(posedge clock); #1;
      req1_valid = 1'b0;
      wait_resp(cyc, ns, sc);
      nCmp++;
      if ({resp_id, resp_q, resp_r, resp_dz} !== {1'b1, 32'd4, 32'd1, 1'b0}) begin
         nErr++;
         $display("FAIL tie_second: got id=%b q=%0d r=%0d dz=%b want 1/4/1/0",
                  resp_id, resp_q, resp_r, resp_dz);
      end
      release_resp();
   endtask

   task automatic test_div_zero();
      int cyc, ns, sc;
      @(negedge clock);
      req1_valid = 1'b1; req1_a = 32'h1234; req1_b = 0;
      #1;
      nCmp++;
      if (req1_ready !== 1'b1 || div_start !== 1'b0) begin
         nErr++;
         $display("FAIL dz_accept: got r1=%b start=%b want 1/0", req1_ready, div_start);
      end
      @(posedge clock); #1;
      req1_valid = 1'b0;
      wait_resp(cyc, ns, sc);
      nCmp++;
      if (cyc !== 1 || ns !== 0) begin
         nErr++; $display("FAIL dz_timing: got cyc=%0d starts=%0d want 1/0", cyc, ns);
      end
      nCmp++;
      if ({resp_id, resp_q, resp_r, resp_dz} !== {1'b1, 32'hFFFFFFFF, 32'h1234, 1'b1}) begin
         nErr++;
         $display("FAIL dz_result: got id=%b q=%h r=%h dz=%b want 1/ffffffff/1234/1",
                  resp_id, resp_q, resp_r, resp_dz);
      end
      release_resp();
   endtask

   task automatic test_hold();
      int cyc, ns, sc;
      @(negedge clock);
      req0_valid = 1'b1; req0_a = 20; req0_b = 3;
      @(posedge clock); #1;
      req0_valid = 1'b0;
      wait_resp(cyc, ns, sc);
      req0_valid = 1'b1; req0_a = 5; req0_b = 5;
      req1_valid = 1'b1; req1_a = 6; req1_b = 6;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         nCmp++;
         if ({resp_valid, resp_id, resp_q, resp_r, resp_dz, busy, req0_ready, req1_ready}
             !== {1'b1, 1'b0, 32'd6, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            nErr++;
            $display("FAIL hold_%0d: got rv=%b q=%0d r=%0d busy=%b r0=%b r1=%b want 1/6/2/1/0/0",
                     i, resp_valid, resp_q, resp_r, busy, req0_ready, req1_ready);
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      release_resp();
      nCmp++;
      if (busy !== 1'b0 || resp_valid !== 1'b0) begin
         nErr++; $display("FAIL hold_release: got busy=%b rv=%b want 0/0", busy, resp_valid);
      end
   endtask

   task automatic test_reset_midop();
      int cyc, ns, sc;
      @(negedge clock);
      req0_valid = 1'b1; req0_a = 77; req0_b = 4;
      @(posedge clock); #1;
      req0_valid = 1'b0;
      repeat (11) @(negedge clock);
      nCmp++;
      if (busy !== 1'b1 || resp_valid !== 1'b0) begin
         nErr++; $display("FAIL midop_busy: got busy=%b rv=%b want 1/0", busy, resp_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      nCmp++;
      if ({req0_ready, req1_ready, resp_valid, resp_id, resp_q, resp_r,
           resp_dz, busy, div_start, div_a, div_b} !== '0) begin
         nErr++;
         $display("FAIL midop_reset: got busy=%b a=%h b=%h start=%b rv=%b",
                  busy, div_a, div_b, div_start, resp_valid);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      req0_valid = 1'b1; req0_a = 32'hFFFFFFFF; req0_b = 1;
      @(posedge clock); #1;
      req0_valid = 1'b0;
      wait_resp(cyc, ns, sc);
      nCmp++;
      if ({resp_q, resp_r, cyc} !== {32'hFFFFFFFF, 32'd0, 32'd35}) begin
         nErr++;
         $display("FAIL midop_after: got q=%h r=%h cyc=%0d want ffffffff/0/35",
                  resp_q, resp_r, cyc);
      end
      release_resp();
   endtask

   task automatic test_operand_hold();
      int cyc;
      int bad;
      @(negedge clock);
      req0_valid = 1'b1; req0_a = 1000; req0_b = 33;
      @(posedge clock); #1;
      cyc = 0;
      bad = 0;
      do begin
         req0_a = $urandom;
         req0_b = $urandom;
         @(negedge clock);
         cyc++;
         nCmp++;
         if (div_a !== 1000 || div_b !== 33) begin
            nErr++;
            bad++;
            if (bad < 4)
               $display("FAIL opnd_hold_%0d: got %0d/%0d want 1000/33", cyc, div_a, div_b);
         end
      end while (!resp_valid && cyc < 200);
      req0_valid = 1'b0;
      nCmp++;
      if ({resp_q, resp_r, resp_id} !== {32'd30, 32'd10, 1'b0} || cyc !== 35) begin
         nErr++;
         $display("FAIL opnd_result: got q=%0d r=%0d id=%b cyc=%0d want 30/10/0/35",
                  resp_q, resp_r, resp_id, cyc);
      end
      release_resp();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_div_zero();
      test_hold();
      test_reset_midop();
      test_operand_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
